// File: rtl/sub_serial32.sv
`default_nettype none
// ============================================================================
// Module   : sub_serial32
// Brief    : Digit-serial subtractor, a - b as a + ~b + 1, LSB slice first,
//            with borrow/overflow/zero/negative flags and valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
module sub_serial32 #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_overflow;
    logic             r_zero;
    logic             r_negative;

    logic [DIGIT:0]   w_slice;
    logic [WIDTH-1:0] w_acc_next;

    // Operands shift right each cycle so the active slice is always the low
    // digit; results enter the accumulator from the top and land in place
    // after NSLICE cycles.
    assign w_slice    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, ~r_b[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, r_carry};
    assign w_acc_next = WIDTH'({w_slice[DIGIT-1:0], r_acc} >> DIGIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_k     <= '0;
                        r_carry <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_slice[DIGIT];
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_k     <= r_k + 1'b1;
                    if (r_k == C_LAST) begin
                        r_diff     <= w_acc_next;
                        r_borrow   <= ~w_slice[DIGIT];
                        r_overflow <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_acc_next[WIDTH-1]);
                        r_zero     <= ~|w_acc_next;
                        r_negative <= w_acc_next[WIDTH-1];
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign negative  = r_negative;

endmodule
`default_nettype wire

// File: doc/sub_serial32.md
Name: sub_serial32

Overview:
- Digit-serial subtractor for the ALU datapath; the inverse operation of the combinational carry-lookahead adder.
- Computes a - b one DIGIT-wide slice per clock, LSB slice first, using a + ~b + 1 with a registered carry between slices.
- Produces unsigned borrow, signed overflow, zero and negative flags.
- Valid/ready handshake on input and output; used where area matters more than single-cycle latency.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; NSLICE = WIDTH/DIGIT (8 at defaults).

Ports:
- clk  input  1  clock, all state changes on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands a, b present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  diff and flags valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  1 when a < b, unsigned compare
- overflow  output  1  signed two's-complement overflow
- zero  output  1  diff == 0
- negative  output  1  diff[WIDTH-1]
- busy  output  1  state != IDLE

Behaviour:
- Reset: rst_n sampled low at an edge sets state to IDLE and clears slice counter, carry, accumulator, diff and all flags to 0. Resulting outputs: in_ready=1, out_valid=0, busy=0.
- Reset mid-RUN or mid-DONE aborts the operation. No result is ever presented for the aborted operation.
- State machine:
  - IDLE: in_ready=1. On an edge with in_valid=1, capture a and b into internal registers, set counter=0 and carry=1, go to RUN.
  - RUN: in_ready=0. Each edge computes {c, s} = a_slice[k] + ~b_slice[k] + carry, writes s into accumulator slice k, sets carry=c and increments k.
  - RUN exit: on the edge processing k = NSLICE-1, go to DONE and load diff and the flags from the final values.
  - DONE: out_valid=1, in_ready=0. On an edge with out_ready=1, go to IDLE.
- Latency: the acceptance edge is T0. out_valid is high after edge T0+NSLICE (8 at defaults) and stays high until the handshake edge.
- Throughput: one operation per NSLICE+2 cycles minimum. in_valid is ignored outside IDLE; there is no accept in the same cycle as the DONE handshake.
- Flag definitions, all registered at the RUN->DONE edge:
  - borrow = ~c_final, where c_final is the carry out of the last slice.
  - overflow = (a[W-1]^b[W-1]) & (a[W-1]^diff[W-1]).
  - zero = ~|diff.
  - negative = diff[W-1].
- Output stability: diff and flags hold their last values outside DONE. They change only at the RUN->DONE edge or on reset. They are stable while out_valid=1 and out_ready=0.
- Operand capture: a and b are sampled only at acceptance. Input changes during RUN have no effect.
- out_ready asserted outside DONE has no effect.

Test Plan:
- 5 - 3, out_ready=1 -> diff=0x00000002, borrow=0, overflow=0, zero=0, negative=0; out_valid rises exactly 8 cycles after the accept edge.
- 0 - 1 -> diff=0xFFFFFFFF, borrow=1, negative=1, overflow=0, zero=0. Also 0x00010000 - 1 -> diff=0x0000FFFF, borrow=0, which checks carry across 4 slices.
- 0x80000000 - 0x00000001 -> diff=0x7FFFFFFF, overflow=1, borrow=0, negative=0. Also 0x7FFFFFFF - 0xFFFFFFFF -> diff=0x80000000, overflow=1, borrow=1.
- 0x12345678 - 0x12345678 -> diff=0, zero=1, borrow=0, overflow=0, negative=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with new operands 9, 4 -> diff/flags stable, in_ready=0, no second accept. On the handshake, return to IDLE; the next edge accepts 9, 4 and yields diff=5 eight cycles later.
- Reset mid-op: drive rst_n=0 at the 4th RUN cycle -> next cycle diff=0, flags=0, out_valid=0, in_ready=1, busy=0. The following op 100 - 1 yields diff=99 with no residue from the aborted op.
